mac_sum_normalizer: RTL and testbench

//  Receiving end of the MSB incrementer in the FP MAC datapath. Takes the compound-adder

---
 rtl/mac_sum_normalizer_if.sv | 49 ++++
 rtl/mac_sum_normalizer.sv | 113 +++++++++++
 tb/tb_mac_sum_normalizer.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_sum_normalizer_if.sv
// Beat-level handshake and data bundle between the compound adder and the rounding stage.
// MAC_SUM_STICKY_EN adds the sticky_o result bit.
interface mac_sum_normalizer_if #(
  parameter int PARM_MANT = 23,
  parameter int PARM_LOW  = 2*PARM_MANT+2,
  parameter int PARM_EXP  = 8
);
  localparam int H = PARM_MANT + 4;
  localparam int L = PARM_LOW;
  localparam int W = H + L;
  localparam int E = PARM_EXP + 2;

  logic         in_valid_i;
  logic         in_ready_o;
  logic         sub_i;
  logic         sign_i;
  logic [E-1:0] exp_i;
  logic [L-1:0] low_sum_i;
  logic [L-1:0] low_sum_inv_i;
  logic [H-1:0] high_sum_i;
  logic [H-1:0] high_sum_inv_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [W-1:0] norm_o;
  logic [E-1:0] exp_o;
  logic         sign_o;
  logic         zero_o;
`ifdef MAC_SUM_STICKY_EN
  logic         sticky_o;
`endif

  modport slave (
    input  in_valid_i, sub_i, sign_i, exp_i, low_sum_i, low_sum_inv_i,
    input  high_sum_i, high_sum_inv_i, out_ready_i,
`ifdef MAC_SUM_STICKY_EN
    output sticky_o,
`endif
    output in_ready_o, out_valid_o, norm_o, exp_o, sign_o, zero_o
  );

  modport master (
    output in_valid_i, sub_i, sign_i, exp_i, low_sum_i, low_sum_inv_i,
    output high_sum_i, high_sum_inv_i, out_ready_i,
`ifdef MAC_SUM_STICKY_EN
    input  sticky_o,
`endif
    input  in_ready_o, out_valid_o, norm_o, exp_o, sign_o, zero_o
  );
endinterface

// File: rtl/mac_sum_normalizer.sv
// Two-stage select/normalize pipeline behind the MSB incrementer of the FP MAC.
// Optional feature macro: MAC_SUM_STICKY_EN (adds stage-2 sticky_o output).
module mac_sum_normalizer #(
  parameter int PARM_MANT = 23,
  parameter int PARM_LOW  = 2*PARM_MANT+2,
  parameter int PARM_EXP  = 8
) (
  input logic clk_i,
  input logic rst_ni,
  mac_sum_normalizer_if.slave bus
);
  localparam int H   = PARM_MANT + 4;
  localparam int L   = PARM_LOW;
  localparam int W   = H + L;
  localparam int E   = PARM_EXP + 2;
  localparam int LZW = $clog2(W + 1);

  logic         v1_q, v1_d, v2_q, v2_d;
  logic [W-1:0] mag1_q, mag1_d;
  logic [E-1:0] exp1_q, exp1_d;
  logic         sign1_q, sign1_d;
  logic [W-1:0] norm_q, norm_d;
  logic [E-1:0] exp2_q, exp2_d;
  logic         sign2_q, sign2_d;
  logic         zero_q, zero_d;
  logic         sticky_q, sticky_d;

  logic           ready1, ready2, in_xfer, mid_xfer, neg, found;
  logic [LZW-1:0] lzc;

  always_comb begin
    ready2   = !v2_q | bus.out_ready_i;
    ready1   = !v1_q | ready2;
    in_xfer  = bus.in_valid_i & ready1;
    mid_xfer = v1_q & ready2;

    v1_d    = ready1 ? bus.in_valid_i : v1_q;
    v2_d    = ready2 ? v1_q : v2_q;
    mag1_d  = mag1_q;
    exp1_d  = exp1_q;
    sign1_d = sign1_q;

    neg = bus.sub_i & bus.high_sum_i[H-1];
    if (in_xfer) begin
      mag1_d  = neg ? {bus.high_sum_inv_i, bus.low_sum_inv_i}
                    : {bus.high_sum_i, bus.low_sum_i};
      exp1_d  = bus.exp_i;
      sign1_d = bus.sign_i ^ neg;
    end

    // Leading-zero count from the MSB; all-zero magnitude yields W.
    lzc   = LZW'(W);
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found && mag1_q[i]) begin
        lzc   = LZW'(W - 1 - i);
        found = 1'b1;
      end
    end

    norm_d   = norm_q;
    exp2_d   = exp2_q;
    sign2_d  = sign2_q;
    zero_d   = zero_q;
    sticky_d = sticky_q;
    if (mid_xfer) begin
      norm_d   = mag1_q << lzc;
      exp2_d   = exp1_q - E'(lzc);
      zero_d   = !found;
      sign2_d  = found & sign1_q;
      sticky_d = found & (|norm_d[W-PARM_MANT-4:0]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      mag1_q   <= '0;
      exp1_q   <= '0;
      sign1_q  <= 1'b0;
      norm_q   <= '0;
      exp2_q   <= '0;
      sign2_q  <= 1'b0;
      zero_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      mag1_q   <= mag1_d;
      exp1_q   <= exp1_d;
      sign1_q  <= sign1_d;
      norm_q   <= norm_d;
      exp2_q   <= exp2_d;
      sign2_q  <= sign2_d;
      zero_q   <= zero_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.in_ready_o  = ready1;
  assign bus.out_valid_o = v2_q;
  assign bus.norm_o      = norm_q;
  assign bus.exp_o       = exp2_q;
  assign bus.sign_o      = sign2_q;
  assign bus.zero_o      = zero_q;
`ifdef MAC_SUM_STICKY_EN
  assign bus.sticky_o    = sticky_q;
`else
  logic unused_sticky;
  assign unused_sticky = sticky_q;
`endif
endmodule

// File: tb/tb_mac_sum_normalizer.sv
// Self-checking bench for mac_sum_normalizer: directed vectors, stall/backpressure,
// async reset, randomized traffic against a queue-based reference model.
module tb_mac_sum_normalizer;
  localparam int H = 27;
  localparam int L = 48;
  localparam int W = 75;
  localparam int E = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  mac_sum_normalizer_if #(.PARM_MANT(23), .PARM_LOW(48), .PARM_EXP(8)) bus ();

  mac_sum_normalizer #(.PARM_MANT(23), .PARM_LOW(48), .PARM_EXP(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [W-1:0] norm;
    logic [E-1:0] exp;
    logic         sign;
    logic         zero;
    logic         sticky;
  } res_t;

  typedef struct {
    logic         sub;
    logic         sign;
    logic [E-1:0] exp;
    logic [L-1:0] lo;
    logic [L-1:0] loi;
    logic [H-1:0] hi;
    logic [H-1:0] hii;
  } beat_t;

  res_t exp_q[$];

  // Reference: pick the magnitude, then shift left one place at a time until the MSB is set.
  function automatic res_t model(input beat_t b);
    res_t         r;
    logic [W-1:0] m;
    int           n;
    if (b.sub && b.hi[H-1]) begin
      m      = {b.hii, b.loi};
      r.sign = !b.sign;
    end else begin
      m      = {b.hi, b.lo};
      r.sign = b.sign;
    end
    n = 0;
    if (m == '0) n = W;
    else while (!m[W-1]) begin
      m = m << 1;
      n++;
    end
    r.norm   = m;
    r.exp    = b.exp - E'(n);
    r.zero   = (n == W);
    if (r.zero) r.sign = 1'b0;
    r.sticky = ((m << (H - 1)) != '0);
    return r;
  endfunction

  function automatic beat_t rand_beat();
    beat_t        b;
    logic [W-1:0] a, c;
    a = {$urandom, $urandom, $urandom};
    c = {$urandom, $urandom, $urandom};
    a = a >> $urandom_range(0, W);
    c = c >> $urandom_range(0, W);
    if ($urandom_range(0, 1) == 1) a[W-1] = 1'b1;
    b.sub  = 1'($urandom_range(0, 1));
    b.sign = 1'($urandom_range(0, 1));
    b.exp  = E'($urandom);
    {b.hi, b.lo}   = a;
    {b.hii, b.loi} = c;
    return b;
  endfunction

  task automatic set_in(input logic v, input beat_t b);
    bus.in_valid_i     = v;
    bus.sub_i          = b.sub;
    bus.sign_i         = b.sign;
    bus.exp_i          = b.exp;
    bus.low_sum_i      = b.lo;
    bus.low_sum_inv_i  = b.loi;
    bus.high_sum_i     = b.hi;
    bus.high_sum_inv_i = b.hii;
  endtask

  task automatic test_reset();
    beat_t z;
    z = '{default: '0};
    set_in(1'b0, z);
    bus.out_ready_i = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1)
      $display("FAIL reset_handshake: out_valid=%b in_ready=%b, want 0/1", bus.out_valid_o, bus.in_ready_o);
    else pass_cnt++;
    total_cnt++;
    if (bus.norm_o !== '0 || bus.exp_o !== '0 || bus.sign_o !== 1'b0 || bus.zero_o !== 1'b0)
      $display("FAIL reset_data: norm=%h exp=%h sign=%b zero=%b, want all 0",
               bus.norm_o, bus.exp_o, bus.sign_o, bus.zero_o);
    else pass_cnt++;
  endtask

  task automatic test_vectors();
    beat_t        b[3];
    logic [W-1:0] w_norm[3];
    logic [E-1:0] w_exp[3];
    logic         w_sign[3], w_zero[3];
    b[0] = '{sub: 1'b0, sign: 1'b1, exp: 10'd10, lo: '0, loi: '1, hi: 27'h1, hii: '1};
    b[1] = '{sub: 1'b1, sign: 1'b0, exp: 10'd0, lo: '1, loi: 48'h1, hi: 27'h4000000, hii: '0};
    b[2] = '{sub: 1'b1, sign: 1'b1, exp: 10'd5, lo: '0, loi: '0, hi: '0, hii: '0};
    w_norm[0] = '0; w_norm[0][W-1] = 1'b1;
    w_norm[1] = w_norm[0];
    w_norm[2] = '0;
    w_exp[0] = -10'sd16; w_exp[1] = -10'sd74; w_exp[2] = -10'sd70;
    w_sign[0] = 1'b1; w_sign[1] = 1'b1; w_sign[2] = 1'b0;
    w_zero[0] = 1'b0; w_zero[1] = 1'b0; w_zero[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.out_ready_i = 1'b1;
      set_in(1'b1, b[k]);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid_i = 1'b0;
      #1;
      total_cnt++;
      if (bus.out_valid_o !== 1'b0)
        $display("FAIL vec%0d_latency: out_valid=%b after 1 cycle, want 0", k, bus.out_valid_o);
      else pass_cnt++;
      @(posedge clk);
      #1;
      total_cnt++;
      if (bus.out_valid_o !== 1'b1 || bus.norm_o !== w_norm[k] || bus.exp_o !== w_exp[k] ||
          bus.sign_o !== w_sign[k] || bus.zero_o !== w_zero[k])
        $display("FAIL vec%0d: valid=%b norm=%h exp=%h sign=%b zero=%b, want 1 %h %h %b %b",
                 k, bus.out_valid_o, bus.norm_o, bus.exp_o, bus.sign_o, bus.zero_o,
                 w_norm[k], w_exp[k], w_sign[k], w_zero[k]);
      else pass_cnt++;
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    beat_t b[3];
    res_t  w[3];
    res_t  got;
    int    sent = 0, rcvd = 0;
    for (int k = 0; k < 3; k++) begin
      b[k] = rand_beat();
      w[k] = model(b[k]);
    end
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      bus.out_ready_i = (cyc >= 4);
      set_in(sent < 3, b[sent < 3 ? sent : 2]);
      #1;
      if (cyc == 3) begin
        total_cnt++;
        if (sent !== 2 || bus.in_ready_o !== 1'b0 || bus.out_valid_o !== 1'b1)
          $display("FAIL b2b_stall: accepted=%0d in_ready=%b out_valid=%b, want 2/0/1",
                   sent, bus.in_ready_o, bus.out_valid_o);
        else pass_cnt++;
      end
      if (bus.out_valid_o && bus.out_ready_i) begin
        got = '{bus.norm_o, bus.exp_o, bus.sign_o, bus.zero_o, 1'b0};
        total_cnt++;
        if (rcvd >= 3) $display("FAIL b2b_extra: got beat %0d, want only 3", rcvd);
        else if (got.norm !== w[rcvd].norm || got.exp !== w[rcvd].exp ||
                 got.sign !== w[rcvd].sign || got.zero !== w[rcvd].zero)
          $display("FAIL b2b_out%0d: norm=%h exp=%h sign=%b zero=%b, want %h %h %b %b", rcvd,
                   got.norm, got.exp, got.sign, got.zero,
                   w[rcvd].norm, w[rcvd].exp, w[rcvd].sign, w[rcvd].zero);
        else pass_cnt++;
        rcvd++;
      end
      if (bus.in_valid_i && bus.in_ready_o) sent++;
    end
    total_cnt++;
    if (rcvd !== 3) $display("FAIL b2b_count: received %0d, want 3", rcvd);
    else pass_cnt++;
  endtask

  task automatic test_random();
    beat_t b;
    res_t  got, w;
    logic  stalled = 1'b0;
    res_t  held;
    int    errs = 0;
    b = rand_beat();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      bus.out_ready_i = (cyc >= 590) ? 1'b1 : ($urandom_range(0, 9) < 7);
      set_in((cyc < 590) && ($urandom_range(0, 9) < 7), b);
      #1;
      got = '{bus.norm_o, bus.exp_o, bus.sign_o, bus.zero_o, 1'b0};
      if (stalled) begin
        total_cnt++;
        if (bus.out_valid_o !== 1'b1 || got.norm !== held.norm || got.exp !== held.exp ||
            got.sign !== held.sign || got.zero !== held.zero) begin
          $display("FAIL rnd_hold cyc%0d: valid=%b norm=%h exp=%h, want 1 %h %h",
                   cyc, bus.out_valid_o, got.norm, got.exp, held.norm, held.exp);
          errs++;
        end else pass_cnt++;
      end
      stalled = bus.out_valid_o && !bus.out_ready_i;
      held    = got;
      if (bus.out_valid_o && bus.out_ready_i) begin
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL rnd_spurious cyc%0d: output with empty scoreboard", cyc);
          errs++;
        end else begin
          w = exp_q.pop_front();
          if (got.norm !== w.norm || got.exp !== w.exp || got.sign !== w.sign || got.zero !== w.zero) begin
            $display("FAIL rnd_data cyc%0d: norm=%h exp=%h sign=%b zero=%b, want %h %h %b %b", cyc,
                     got.norm, got.exp, got.sign, got.zero, w.norm, w.exp, w.sign, w.zero);
            errs++;
          end else pass_cnt++;
        end
      end
      if (bus.in_valid_i && bus.in_ready_o) begin
        exp_q.push_back(model(b));
        b = rand_beat();
      end
    end
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL rnd_drain: %0d beats lost, want 0", exp_q.size());
    else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    beat_t b;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.out_ready_i = 1'b0;
      b = rand_beat();
      b.hi[H-1] = 1'b1;
      set_in(1'b1, b);
    end
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    #1;
    total_cnt++;
    if (bus.out_valid_o !== 1'b1 || bus.in_ready_o !== 1'b0)
      $display("FAIL rstmid_full: out_valid=%b in_ready=%b, want 1/0", bus.out_valid_o, bus.in_ready_o);
    else pass_cnt++;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1 || bus.norm_o !== '0)
      $display("FAIL rstmid_async: out_valid=%b in_ready=%b norm=%h, want 0/1/0",
               bus.out_valid_o, bus.in_ready_o, bus.norm_o);
    else pass_cnt++;
    @(posedge clk);
    #3 rst_n = 1'b1;
    bus.out_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total_cnt++;
      if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1)
        $display("FAIL rstmid_stale%0d: out_valid=%b in_ready=%b, want 0/1",
                 k, bus.out_valid_o, bus.in_ready_o);
      else pass_cnt++;
    end
  endtask

`ifdef MAC_SUM_STICKY_EN
  task automatic test_sticky();
    beat_t b[3];
    logic  w[3];
    b[0] = '{sub: 1'b0, sign: 1'b0, exp: 10'd0, lo: 48'h1, loi: '0, hi: 27'h4000000, hii: '0};
    b[1] = '{sub: 1'b0, sign: 1'b0, exp: 10'd0, lo: 48'h0, loi: '1, hi: 27'h4000000, hii: '0};
    b[2] = '{sub: 1'b0, sign: 1'b0, exp: 10'd0, lo: 48'h0, loi: '1, hi: 27'h0, hii: '1};
    w[0] = 1'b1; w[1] = 1'b0; w[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.out_ready_i = 1'b1;
      set_in(1'b1, b[k]);
      @(negedge clk);
      bus.in_valid_i = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (bus.out_valid_o !== 1'b1 || bus.sticky_o !== w[k])
        $display("FAIL sticky%0d: valid=%b sticky=%b, want 1/%b", k, bus.out_valid_o, bus.sticky_o, w[k]);
      else pass_cnt++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef MAC_SUM_STICKY_EN
    test_sticky();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
